writeback_arbiter: RTL and testbench

Shares the single register-file write port between execution pipes A and B, which both retire results after the dependency-resolution stage has issued them. Each pipe hands over a result through a valid/ready handshake into a one-entry holding buffer. An age-ordered arbiter drains the buffers to the write port one per cycle. Every committed write is echoed on a clear port so the register blocking file can release the destination register early.

---
 rtl/writeback_arbiter.sv | 131 +++++++++++++
 tb/tb_writeback_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Shares one register-file write port between pipes A and B: each pipe feeds a
// one-entry holding buffer, drained oldest-first with the commit echoed on the clear port.

module wbBuffer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load,
    input  logic                  drain,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  bufValid,
    output logic [ADDR_WIDTH-1:0] bufAddr,
    output logic [DATA_WIDTH-1:0] bufData
);
    // Load wins over drain so a buffer emptied on an edge refills on that same edge.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            bufValid <= 1'b0;
            bufAddr  <= '0;
            bufData  <= '0;
        end else if (load) begin
            bufValid <= 1'b1;
            bufAddr  <= addr;
            bufData  <= data;
        end else if (drain) begin
            bufValid <= 1'b0;
        end
    end
endmodule

module writeback_arbiter #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   validA_i,
    input  logic [ADDR_WIDTH-1:0]  addrA_i,
    input  logic [DATA_WIDTH-1:0]  dataA_i,
    output logic                   readyA_o,
    input  logic                   validB_i,
    input  logic [ADDR_WIDTH-1:0]  addrB_i,
    input  logic [DATA_WIDTH-1:0]  dataB_i,
    output logic                   readyB_o,
    input  logic                   hold_i,
    output logic                   wrEnable_o,
    output logic [ADDR_WIDTH-1:0]  wrAddr_o,
    output logic [DATA_WIDTH-1:0]  wrData_o,
    output logic                   clearValid_o,
    output logic [ADDR_WIDTH-1:0]  clearAddr_o,
    output logic [COUNT_WIDTH-1:0] collisionCount_o
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Index 0 is pipe A, index 1 is pipe B.
    logic [1:0]                 inValid, bufValid, grant, ready, load, postValid;
    logic [1:0][ADDR_WIDTH-1:0] inAddr, bufAddr;
    logic [1:0][DATA_WIDTH-1:0] inData, bufData;
    logic                       olderIsA, olderNext;

    assign inValid = {validB_i, validA_i};
    assign inAddr  = {addrB_i, addrA_i};
    assign inData  = {dataB_i, dataA_i};

    assign grant[0]  = !hold_i && bufValid[0] && (!bufValid[1] || olderIsA);
    assign grant[1]  = !hold_i && bufValid[1] && (!bufValid[0] || !olderIsA);
    assign ready     = {2{reset_i}} & (~bufValid | grant);
    assign load      = inValid & ready;
    assign postValid = load | (bufValid & ~grant);

    assign readyA_o = ready[0];
    assign readyB_o = ready[1];

    for (genvar p = 0; p < 2; p++) begin : gPipe
        wbBuffer #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) uBuf (
            .clock_i  (clock_i),
            .reset_i  (reset_i),
            .load     (load[p]),
            .drain    (grant[p]),
            .addr     (inAddr[p]),
            .data     (inData[p]),
            .bufValid (bufValid[p]),
            .bufAddr  (bufAddr[p]),
            .bufData  (bufData[p])
        );
    end

    // With both occupied afterwards, a freshly loaded B (alone or alongside A)
    // makes A the elder; a freshly loaded A alone makes B the elder.
    always_comb begin
        olderNext = olderIsA;
        case (postValid)
            2'b01: olderNext = 1'b1;
            2'b10: olderNext = 1'b0;
            2'b11: begin
                if (load[1])      olderNext = 1'b1;
                else if (load[0]) olderNext = 1'b0;
            end
            default: olderNext = olderIsA;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            olderIsA         <= 1'b1;
            collisionCount_o <= '0;
            wrEnable_o       <= 1'b0;
            wrAddr_o         <= '0;
            wrData_o         <= '0;
        end else begin
            olderIsA <= olderNext;
            if (&bufValid && collisionCount_o != COUNT_MAX)
                collisionCount_o <= collisionCount_o + 1'b1;
            wrEnable_o <= |grant;
            if (grant[1]) begin
                wrAddr_o <= bufAddr[1];
                wrData_o <= bufData[1];
            end else if (grant[0]) begin
                wrAddr_o <= bufAddr[0];
                wrData_o <= bufData[0];
            end
        end
    end

    assign clearValid_o = wrEnable_o;
    assign clearAddr_o  = wrAddr_o;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench: an age-ordered pending list predicts readies and writes.

module tb_writeback_arbiter;
    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        validA_i = 1'b0, validB_i = 1'b0, hold_i = 1'b0;
    logic [4:0]  addrA_i = '0, addrB_i = '0;
    logic [15:0] dataA_i = '0, dataB_i = '0;
    logic        readyA_o, readyB_o, wrEnable_o, clearValid_o;
    logic [4:0]  wrAddr_o, clearAddr_o;
    logic [15:0] wrData_o;
    logic [7:0]  collisionCount_o;

    writeback_arbiter dut (
        .clock_i(clock_i), .reset_i(reset_i),
        .validA_i(validA_i), .addrA_i(addrA_i), .dataA_i(dataA_i), .readyA_o(readyA_o),
        .validB_i(validB_i), .addrB_i(addrB_i), .dataB_i(dataB_i), .readyB_o(readyB_o),
        .hold_i(hold_i), .wrEnable_o(wrEnable_o), .wrAddr_o(wrAddr_o), .wrData_o(wrData_o),
        .clearValid_o(clearValid_o), .clearAddr_o(clearAddr_o),
        .collisionCount_o(collisionCount_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic        pipeB;
        logic [4:0]  addr;
        logic [15:0] data;
    } entry_t;

    entry_t pend[$];   // results held by the arbiter, oldest first
    entry_t expQ[$];   // writes the DUT owes, in order
    int     tests = 0, failed = 0;
    int     mCount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit holds(input logic pipeB);
        foreach (pend[i]) if (pend[i].pipeB == pipeB) return 1'b1;
        return 1'b0;
    endfunction

    // Monitor: every write strobe consumes the next owed write.
    always @(negedge clock_i) begin
        if (wrEnable_o === 1'b1) begin
            if (expQ.size() == 0) begin
                tests++; failed++;
                $display("FAIL unexpected_write: got r%0d=%0h expected no write", wrAddr_o, wrData_o);
            end else begin
                entry_t e;
                e = expQ.pop_front();
                chk("wrAddr", 32'(wrAddr_o), 32'(e.addr));
                chk("wrData", 32'(wrData_o), 32'(e.data));
                chk("clearValid", 32'(clearValid_o), 32'd1);
                chk("clearAddr", 32'(clearAddr_o), 32'(e.addr));
            end
        end
    end

    // One clock: drive, check readies against the model, advance the model, wait.
    task automatic step(input logic r, input logic vA, input logic [4:0] aA, input logic [15:0] dA,
                        input logic vB, input logic [4:0] aB, input logic [15:0] dB, input logic h);
        logic mRdyA, mRdyB;
        reset_i = r; validA_i = vA; addrA_i = aA; dataA_i = dA;
        validB_i = vB; addrB_i = aB; dataB_i = dB; hold_i = h;
        #1;
        mRdyA = r && (!holds(1'b0) || (!h && !pend[0].pipeB));
        mRdyB = r && (!holds(1'b1) || (!h && pend[0].pipeB));
        chk("readyA", 32'(readyA_o), 32'(mRdyA));
        chk("readyB", 32'(readyB_o), 32'(mRdyB));
        if (!r) begin
            pend.delete();
            mCount = 0;
        end else begin
            if (pend.size() == 2 && mCount < 255) mCount++;
            if (!h && pend.size() > 0) expQ.push_back(pend.pop_front());
            if (vA && mRdyA) pend.push_back('{1'b0, aA, dA});
            if (vB && mRdyB) pend.push_back('{1'b1, aB, dB});
        end
        @(negedge clock_i);
        chk("collisionCount", 32'(collisionCount_o), 32'(mCount));
    endtask

    task automatic idle(input int n, input logic h);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, h);
    endtask

    initial begin
        @(negedge clock_i);
        // Reset with both pipes offering: readies must stay low.
        step(1'b0, 1'b1, 5'd1, 16'h0101, 1'b1, 5'd2, 16'h0202, 1'b0);
        step(1'b0, 1'b1, 5'd1, 16'h0101, 1'b1, 5'd2, 16'h0202, 1'b0);
        chk("rst_wrEnable", 32'(wrEnable_o), 32'd0);
        chk("rst_wrAddr", 32'(wrAddr_o), 32'd0);
        chk("rst_wrData", 32'(wrData_o), 32'd0);
        chk("rst_clearValid", 32'(clearValid_o), 32'd0);
        chk("rst_clearAddr", 32'(clearAddr_o), 32'd0);

        // Single pipe streaming r3..r6.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 5'(3 + i), 16'(16'h1111 * (i + 1)), 1'b0, 5'd0, 16'd0, 1'b0);
        idle(2, 1'b0);

        // Same destination on the same edge: A then B.
        step(1'b1, 1'b1, 5'd7, 16'hAAAA, 1'b1, 5'd7, 16'hBBBB, 1'b0);
        idle(3, 1'b0);

        // Age order across a hold: B accepted before A.
        step(1'b1, 1'b0, 5'd0, 16'd0, 1'b1, 5'd2, 16'h0002, 1'b1);
        step(1'b1, 1'b1, 5'd9, 16'h0009, 1'b0, 5'd0, 16'd0, 1'b1);
        step(1'b1, 1'b1, 5'd10, 16'h0010, 1'b0, 5'd0, 16'd0, 1'b1);
        chk("held_no_write", 32'(wrEnable_o), 32'd0);
        idle(4, 1'b0);

        // Both pipes saturating the port.
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 5'($urandom), 16'($urandom), 1'b1, 5'($urandom), 16'($urandom), 1'b0);
        chk("count_saturated", 32'(collisionCount_o), 32'd255);
        idle(4, 1'b0);

        // Random traffic with random holds.
        for (int i = 0; i < 400; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 5'($urandom), 16'($urandom),
                 ($urandom_range(0, 3) == 0));
        idle(4, 1'b0);

        // Reset while both buffers are full discards them.
        step(1'b1, 1'b1, 5'd11, 16'h1111, 1'b1, 5'd12, 16'h2222, 1'b1);
        step(1'b1, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 5'd0, 16'd0, 1'b0);
        step(1'b1, 1'b1, 5'd13, 16'h3333, 1'b0, 5'd0, 16'd0, 1'b0);
        idle(4, 1'b0);

        chk("owed_writes_left", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
